seq_serializer: RTL and testbench

SEQ_SERIALIZER -- requirements
Module: seq_serializer

---
 rtl/seq_pkg.sv | 28 ++
 rtl/seq_serializer_bit_tick.sv | 31 +++
 rtl/seq_serializer.sv | 117 +++++++++++
 tb/tb_seq_serializer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serializer / sequence-detector pair:
// state codes for both FSMs and a counter-width helper.
package seq_pkg;

    // Serializer state codes
    localparam logic [1:0] SER_IDLE  = 2'd0;
    localparam logic [1:0] SER_SHIFT = 2'd1;
    localparam logic [1:0] SER_DONE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = SER_IDLE,
        ST_SHIFT = SER_SHIFT,
        ST_DONE  = SER_DONE
    } ser_state_t;

    // Sequence detector state codes (detects 1101 on the serial stream)
    localparam logic [2:0] DET_S0   = 3'd0;
    localparam logic [2:0] DET_S1   = 3'd1;
    localparam logic [2:0] DET_S11  = 3'd2;
    localparam logic [2:0] DET_S110 = 3'd3;
    localparam logic [2:0] DET_HIT  = 3'd4;

    // Width of a counter that must hold 0..n-1; never less than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_serializer_bit_tick.sv
// Bit-period prescaler: counts 0..DIV-1 and flags the last cycle of
// each bit period with tick. clear holds the count at zero.
module bit_tick
    import seq_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic clr_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = cnt_width(DIV);

    logic [CW-1:0] cnt_reg;

    // Free-running modulo-DIV count, restarted whenever clear is high
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_reg <= '0;
        end else if (clear || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign tick = (cnt_reg == CW'(DIV - 1));

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial converter: accepts a WIDTH-bit word on a
// valid/ready handshake and shifts it out MSB first, each bit held
// for DIV clock cycles, followed by a one-cycle done pulse.
module seq_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             bit_strobe,
    output logic             busy,
    output logic             done
);

    generate
        if (WIDTH < 2 || DIV < 1) begin : g_bad_params
            $error("seq_serializer: WIDTH must be >= 2 and DIV >= 1");
        end
    endgenerate

    localparam int BW = cnt_width(WIDTH);

    ser_state_t       state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
    logic             strobe_reg, strobe_next;
    logic             tick;
    logic             tick_clear;

    // Prescaler only runs while shifting, so every word starts at count 0
    assign tick_clear = (state_reg != ST_SHIFT);

    bit_tick #(
        .DIV (DIV)
    ) u_bit_tick (
        .clk   (clk),
        .clr_n (clr_n),
        .clear (tick_clear),
        .tick  (tick)
    );

    // State register; reset aborts any word in flight
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers: shift register, remaining-bit count, strobe
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            strobe_reg  <= 1'b0;
        end else begin
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            strobe_reg  <= strobe_next;
        end
    end

    // Next-state, datapath update and Moore outputs
    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        strobe_next  = 1'b0;
        load_ready   = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        dout         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    shift_next   = load_data;
                    bit_cnt_next = BW'(WIDTH - 1);
                    strobe_next  = 1'b1;
                    state_next   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                dout = shift_reg[WIDTH-1];
                if (tick) begin
                    if (bit_cnt_reg == '0) begin
                        shift_next = '0;
                        state_next = ST_DONE;
                    end else begin
                        // Next bit begins next cycle: advance and strobe it
                        shift_next   = {shift_reg[WIDTH-2:0], 1'b0};
                        bit_cnt_next = bit_cnt_reg - BW'(1);
                        strobe_next  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bit_strobe = strobe_reg;

endmodule

// File: tb/tb_seq_serializer.sv
// Self-checking bench: DUT 0 runs DIV=4, DUT 1 runs DIV=1. Words are
// pushed to a scoreboard when the bench model predicts a handshake and
// popped when the word's first bit is due; every cycle is then checked.
module tb_seq_serializer;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic [7:0] data_a = '0, data_b = '0;
    logic       valid_a = 1'b0, valid_b = 1'b0;
    logic       ready_a, dout_a, strobe_a, busy_a, done_a;
    logic       ready_b, dout_b, strobe_b, busy_b, done_b;

    always #5 clk = ~clk;

    seq_serializer #(.WIDTH(8), .DIV(4)) u_dut_a (
        .clk(clk), .clr_n(clr_n), .load_data(data_a), .load_valid(valid_a),
        .load_ready(ready_a), .dout(dout_a), .bit_strobe(strobe_a),
        .busy(busy_a), .done(done_a)
    );

    seq_serializer #(.WIDTH(8), .DIV(1)) u_dut_b (
        .clk(clk), .clr_n(clr_n), .load_data(data_b), .load_valid(valid_b),
        .load_ready(ready_b), .dout(dout_b), .bit_strobe(strobe_b),
        .busy(busy_b), .done(done_b)
    );

    int chk_count = 0;
    int err_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_count++;
        if (obs !== exp) begin
            err_count++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboards and per-DUT monitor model state
    logic [7:0] sb_q0[$];
    logic [7:0] sb_q1[$];
    bit         mon_active[2];
    bit         mon_pending[2];
    bit         mon_exp_done[2];
    int         mon_cyc[2];
    logic [7:0] mon_word[2];
    logic [3:0] det_hist[2];
    int         det_hits[2];
    int         pushes[2];
    int         done_words[2];

    function automatic int count_1101(input logic [7:0] w);
        int n;
        n = 0;
        for (int i = 0; i <= 4; i++) begin
            if (w[7-i -: 4] == 4'b1101) n++;
        end
        return n;
    endfunction

    task automatic mon_step(input int d, input int div, input logic dout, input logic strobe,
                            input logic busy, input logic done, input logic ready,
                            input logic valid, input logic [7:0] data);
        int k;
        if (mon_pending[d]) begin
            mon_word[d]    = (d == 0) ? sb_q0.pop_front() : sb_q1.pop_front();
            mon_active[d]  = 1'b1;
            mon_cyc[d]     = 0;
            mon_pending[d] = 1'b0;
            det_hist[d]    = '0;
            det_hits[d]    = 0;
        end
        if (mon_active[d]) begin
            k = mon_cyc[d] / div;
            check($sformatf("d%0d_dout_bit%0d", d, k), dout, mon_word[d][7-k]);
            check($sformatf("d%0d_strobe", d), strobe, (mon_cyc[d] % div) == 0);
            check($sformatf("d%0d_busy_shift", d), busy, 1);
            check($sformatf("d%0d_ready_shift", d), ready, 0);
            check($sformatf("d%0d_done_shift", d), done, 0);
            if ((mon_cyc[d] % div) == 0) begin
                det_hist[d] = {det_hist[d][2:0], dout};
                if (det_hist[d] == 4'b1101) det_hits[d]++;
            end
            mon_cyc[d]++;
            if (mon_cyc[d] == 8 * div) begin
                mon_active[d]   = 1'b0;
                mon_exp_done[d] = 1'b1;
            end
        end else if (mon_exp_done[d]) begin
            check($sformatf("d%0d_done", d), done, 1);
            check($sformatf("d%0d_dout_done", d), dout, 0);
            check($sformatf("d%0d_busy_done", d), busy, 0);
            check($sformatf("d%0d_ready_done", d), ready, 0);
            check($sformatf("d%0d_strobe_done", d), strobe, 0);
            check($sformatf("d%0d_det_hits", d), det_hits[d], count_1101(mon_word[d]));
            $display("word d%0d %02h sent, detector hits %0d", d, mon_word[d], det_hits[d]);
            done_words[d]++;
            mon_exp_done[d] = 1'b0;
        end else begin
            check($sformatf("d%0d_ready_idle", d), ready, 1);
            check($sformatf("d%0d_busy_idle", d), busy, 0);
            check($sformatf("d%0d_dout_idle", d), dout, 0);
            check($sformatf("d%0d_done_idle", d), done, 0);
            check($sformatf("d%0d_strobe_idle", d), strobe, 0);
            if (valid) begin
                if (d == 0) sb_q0.push_back(data);
                else        sb_q1.push_back(data);
                mon_pending[d] = 1'b1;
                pushes[d]++;
            end
        end
    endtask

    // Monitor: sample on the falling edge, flush the model during reset
    always @(negedge clk) begin
        if (!clr_n) begin
            for (int d = 0; d < 2; d++) begin
                mon_active[d]   = 1'b0;
                mon_pending[d]  = 1'b0;
                mon_exp_done[d] = 1'b0;
            end
            sb_q0.delete();
            sb_q1.delete();
            check("rst_dout", {dout_a, dout_b}, 2'b00);
            check("rst_busy", {busy_a, busy_b}, 2'b00);
            check("rst_done", {done_a, done_b}, 2'b00);
            check("rst_strobe", {strobe_a, strobe_b}, 2'b00);
        end else begin
            mon_step(0, 4, dout_a, strobe_a, busy_a, done_a, ready_a, valid_a, data_a);
            mon_step(1, 1, dout_b, strobe_b, busy_b, done_b, ready_b, valid_b, data_b);
        end
    end

    // Present a word and wait (bounded) for the modelled handshake
    task automatic send(input int d, input logic [7:0] w, input bit hold);
        int start;
        int n;
        start = pushes[d];
        n = 0;
        if (d == 0) begin data_a = w; valid_a = 1'b1; end
        else        begin data_b = w; valid_b = 1'b1; end
        while (pushes[d] == start && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 500) check($sformatf("d%0d_send_timeout", d), 0, 1);
        if (!hold) begin
            if (d == 0) valid_a = 1'b0;
            else        valid_b = 1'b0;
        end
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while ((mon_active[d] || mon_pending[d] || mon_exp_done[d]) && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        check($sformatf("d%0d_idle_timeout", d), n < 400, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            pushes[d] = 0;
            done_words[d] = 0;
        end
        // Asynchronous reset takes effect without a clock edge
        #2;
        check("rst_async_busy", {busy_a, busy_b}, 2'b00);
        check("rst_async_dout", {dout_a, dout_b}, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        // Release reset with a word already offered: first edge must accept it
        clr_n = 1'b1;
        send(0, 8'hD0, 1'b0);
        wait_idle(0);

        // DIV=1, valid held high across two words
        send(1, 8'hA5, 1'b1);
        send(1, 8'h5A, 1'b0);
        wait_idle(1);

        // Spurious load during SHIFT must be ignored
        send(0, 8'h81, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        data_a = 8'hFF;
        valid_a = 1'b1;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        wait_idle(0);

        // valid held through DONE: next word taken only in IDLE
        send(0, 8'hD0, 1'b1);
        send(0, 8'h3C, 1'b0);
        wait_idle(0);

        // Reset mid-word (cycle N+10) aborts the transfer with no done pulse
        send(0, 8'hFF, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        clr_n = 1'b0;
        #1;
        check("abort_dout", dout_a, 0);
        check("abort_busy", busy_a, 0);
        check("abort_strobe", strobe_a, 0);
        check("abort_done", done_a, 0);
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_ready_after", ready_a, 1);

        // Random words on both instances
        for (int i = 0; i < 4; i++) begin
            send(0, 8'($urandom_range(0, 255)), 1'b0);
            send(1, 8'($urandom_range(0, 255)), 1'b0);
            wait_idle(0);
            wait_idle(1);
        end

        repeat (4) @(posedge clk);
        #1;
        check("sb_leftover", sb_q0.size() + sb_q1.size(), 0);
        check("words_a", done_words[0], 8);
        check("words_b", done_words[1], 6);
        $display("CHECKS %0d ERRORS %0d", chk_count, err_count);
        $finish;
    end

endmodule
